// File: rtl/cmd_frame_decoder.sv
// Command frame decoder: turns the synchronised RX byte stream into regfile and ALU strobes.
// Build option CMD_TIMEOUT_EN adds an inter-byte timeout that abandons a stalled frame.
module cmd_frame_decoder #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUNC_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   input  logic                  alu_done,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  alu_en,
   output logic [FUNC_WIDTH-1:0] alu_func,
   output logic                  clk_gate_en,
   output logic                  frame_err
);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR,
      ALU_OPA, ALU_OPB, ALU_FUNC, WAIT_ALU
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_FN  = DATA_WIDTH'(8'hDD);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] lat_q, lat_d;
   logic                  wr_en_d, rd_en_d, alu_en_d, err_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] wr_data_d;
   logic [FUNC_WIDTH-1:0] func_d;
   logic                  tmo;

`ifdef CMD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q;
   logic          mid;

   assign mid = (state_q != IDLE) && (state_q != WAIT_ALU);
   assign tmo = mid && !rx_valid
             && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         cnt_q <= '0;
      else if (rx_valid || !mid || tmo)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      err_d     = 1'b0;
      addr_d    = addr;
      wr_data_d = wr_data;
      func_d    = alu_func;
      if (tmo) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: if (rx_valid) begin
               unique case (1'b1)
                  (rx_data == CMD_WR):  state_d = WR_ADDR;
                  (rx_data == CMD_RD):  state_d = RD_ADDR;
                  (rx_data == CMD_ALU): state_d = ALU_OPA;
                  (rx_data == CMD_FN):  state_d = ALU_FUNC;
                  default:              err_d   = 1'b1;
               endcase
            end
            WR_ADDR: if (rx_valid) begin
               lat_d   = rx_data[ADDR_WIDTH-1:0];
               state_d = WR_DATA;
            end
            WR_DATA: if (rx_valid) begin
               wr_en_d   = 1'b1;
               addr_d    = lat_q;
               wr_data_d = rx_data;
               state_d   = IDLE;
            end
            RD_ADDR: if (rx_valid) begin
               rd_en_d = 1'b1;
               addr_d  = rx_data[ADDR_WIDTH-1:0];
               state_d = IDLE;
            end
            ALU_OPA: if (rx_valid) begin
               wr_en_d   = 1'b1;
               addr_d    = ADDR_WIDTH'(0);
               wr_data_d = rx_data;
               state_d   = ALU_OPB;
            end
            ALU_OPB: if (rx_valid) begin
               wr_en_d   = 1'b1;
               addr_d    = ADDR_WIDTH'(1);
               wr_data_d = rx_data;
               state_d   = ALU_FUNC;
            end
            ALU_FUNC: if (rx_valid) begin
               alu_en_d = 1'b1;
               func_d   = rx_data[FUNC_WIDTH-1:0];
               state_d  = WAIT_ALU;
            end
            WAIT_ALU: begin
               // stray bytes while the ALU is busy are dropped, not queued
               err_d = rx_valid;
               if (alu_done)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         lat_q       <= '0;
         wr_en       <= 1'b0;
         rd_en       <= 1'b0;
         alu_en      <= 1'b0;
         frame_err   <= 1'b0;
         addr        <= '0;
         wr_data     <= '0;
         alu_func    <= '0;
         clk_gate_en <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         wr_en       <= wr_en_d;
         rd_en       <= rd_en_d;
         alu_en      <= alu_en_d;
         frame_err   <= err_d;
         addr        <= addr_d;
         wr_data     <= wr_data_d;
         alu_func    <= func_d;
         clk_gate_en <= (state_q == ALU_OPA) || (state_q == ALU_OPB)
                     || (state_q == ALU_FUNC) || (state_q == WAIT_ALU);
      end
   end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder; timeout case runs when CMD_TIMEOUT_EN is defined.
module tb_cmd_frame_decoder;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       alu_done = 1'b0;
   logic       wr_en, rd_en, alu_en, clk_gate_en, frame_err;
   logic [3:0] addr, alu_func;
   logic [7:0] wr_data;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int base;

   always #5 CLK = ~CLK;

   cmd_frame_decoder #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4),
      .FUNC_WIDTH(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK(CLK), .RST(RST),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .alu_done(alu_done),
      .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wr_data(wr_data), .alu_en(alu_en),
      .alu_func(alu_func), .clk_gate_en(clk_gate_en),
      .frame_err(frame_err)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic v, input logic [7:0] d,
                       input logic done);
      rx_valid = v;
      rx_data  = d;
      alu_done = done;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
      alu_done = 1'b0;
      if (wr_en) wr_cnt++;
   endtask

   initial begin
      tick(0, 8'h00, 0);
      tick(0, 8'h00, 0);
      chk("rst_wr", wr_en, 0);
      chk("rst_rd", rd_en, 0);
      chk("rst_alu", alu_en, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_cg", clk_gate_en, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_func", alu_func, 0);
      RST = 1'b1;
      tick(0, 8'h00, 0);

      // write frame
      tick(1, 8'hAA, 0);
      tick(1, 8'h05, 0);
      chk("t1_nowr", wr_en, 0);
      tick(1, 8'h3C, 0);
      chk("t1_wr", wr_en, 1);
      chk("t1_addr", addr, 5);
      chk("t1_data", wr_data, 8'h3C);
      chk("t1_err", frame_err, 0);
      tick(0, 8'h00, 0);
      chk("t1_wr_1cyc", wr_en, 0);

      // read with truncated address
      tick(1, 8'hBB, 0);
      tick(1, 8'hF7, 0);
      chk("t2_rd", rd_en, 1);
      chk("t2_addr", addr, 7);
      chk("t2_nowr", wr_en, 0);
      tick(0, 8'h00, 0);
      chk("t2_rd_1cyc", rd_en, 0);

      // ALU frame, then stray byte during wait
      tick(1, 8'hCC, 0);
      chk("t3_cg_lag", clk_gate_en, 0);
      tick(1, 8'h12, 0);
      chk("t3_wra", wr_en, 1);
      chk("t3_adra", addr, 0);
      chk("t3_dataa", wr_data, 8'h12);
      chk("t3_cg_on", clk_gate_en, 1);
      tick(1, 8'h34, 0);
      chk("t3_wrb", wr_en, 1);
      chk("t3_adrb", addr, 1);
      chk("t3_datab", wr_data, 8'h34);
      tick(1, 8'h02, 0);
      chk("t3_alu", alu_en, 1);
      chk("t3_func", alu_func, 2);
      chk("t3_nowr", wr_en, 0);
      tick(0, 8'h00, 0);
      chk("t3_alu_1cyc", alu_en, 0);
      tick(1, 8'h77, 0);
      chk("t3_stray_err", frame_err, 1);
      chk("t3_stray_nowr", wr_en, 0);
      tick(0, 8'h00, 0);
      chk("t3_err_1cyc", frame_err, 0);
      tick(0, 8'h00, 0);
      tick(0, 8'h00, 1);
      chk("t3_cg_hold", clk_gate_en, 1);
      tick(0, 8'h00, 0);
      chk("t3_cg_off", clk_gate_en, 0);

      // alu_done with a byte on the same cycle
      tick(1, 8'hDD, 0);
      tick(1, 8'h04, 0);
      chk("t3b_alu", alu_en, 1);
      chk("t3b_func", alu_func, 4);
      tick(1, 8'h99, 1);
      chk("t3b_err", frame_err, 1);
      tick(1, 8'hBB, 0);
      tick(1, 8'h03, 0);
      chk("t3b_idle_rd", rd_en, 1);
      chk("t3b_idle_addr", addr, 3);

      // alu_done outside WAIT_ALU is ignored
      tick(0, 8'h00, 1);
      chk("t3c_done_ign", frame_err, 0);

      // unknown command, then back-to-back function frame
      tick(1, 8'h55, 0);
      chk("t4_err", frame_err, 1);
      chk("t4_nowr", wr_en, 0);
      chk("t4_nord", rd_en, 0);
      chk("t4_noalu", alu_en, 0);
      tick(1, 8'hDD, 0);
      chk("t4_err_1cyc", frame_err, 0);
      tick(1, 8'h03, 0);
      chk("t4_alu", alu_en, 1);
      chk("t4_func", alu_func, 3);
      tick(0, 8'h00, 0);
      chk("t4_func_hold", alu_func, 3);
      tick(0, 8'h00, 1);
      tick(0, 8'h00, 0);

      // reset mid-frame
      base = wr_cnt;
      tick(1, 8'hAA, 0);
      tick(1, 8'h05, 0);
      RST = 1'b0;
      #1;
      chk("t5_rst_func", alu_func, 0);
      chk("t5_rst_addr", addr, 0);
      tick(0, 8'h00, 0);
      RST = 1'b1;
      tick(1, 8'hAA, 0);
      tick(1, 8'h06, 0);
      tick(1, 8'h99, 0);
      chk("t5_wr", wr_en, 1);
      chk("t5_addr", addr, 6);
      chk("t5_data", wr_data, 8'h99);
      tick(0, 8'h00, 0);
      chk("t5_count", wr_cnt - base, 1);

`ifdef CMD_TIMEOUT_EN
      base = wr_cnt;
      tick(1, 8'hAA, 0);
      tick(1, 8'h05, 0);
      for (int i = 0; i < 15; i++) begin
         tick(0, 8'h00, 0);
         chk("t6_early_err", frame_err, 0);
      end
      tick(0, 8'h00, 0);
      chk("t6_tmo_err", frame_err, 1);
      tick(1, 8'h3C, 0);
      chk("t6_idle_err", frame_err, 1);
      chk("t6_nowr", wr_cnt - base, 0);
`else
      base = wr_cnt;
      tick(1, 8'hAA, 0);
      tick(1, 8'h05, 0);
      for (int i = 0; i < 20; i++) begin
         tick(0, 8'h00, 0);
         chk("t6_wait_err", frame_err, 0);
      end
      tick(1, 8'h3C, 0);
      chk("t6_late_wr", wr_en, 1);
      chk("t6_late_addr", addr, 5);
      chk("t6_count", wr_cnt - base, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
